mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the unpipelined MIPS core.
- Decode raises i_start with the R-type func field. The block then runs an iterative shift-add multiply or restoring divide.
- o_busy stalls the core while a calculation is in progress.
- Serves MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. These func codes are not in the ALU func set.

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_sequencer_if.sv | 29 ++
 rtl/mdu_datapath.sv | 105 ++++++++++
 rtl/mdu_sequencer.sv | 119 +++++++++++
 tb/tb_mdu_sequencer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: func codes, FSM encoding, default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Optional build macro MDU_EARLY_OUT_EN is consumed by mdu_datapath and mdu_sequencer.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 5;

  // R-type func codes served by the MDU
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // MULT/MULTU/DIV/DIVU share the 0110xx prefix; bit 1 selects divide, bit 0 unsigned
  function automatic logic is_muldiv(input logic [5:0] func);
    return func[5:2] == 4'b0110;
  endfunction

  // MFHI/MTHI/MFLO/MTLO share the 0100xx prefix
  function automatic logic is_known(input logic [5:0] func);
    return (func[5:2] == 4'b0110) || (func[5:2] == 4'b0100);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Core <-> MDU request/result bundle.
// Latency: n/a (wiring only).
// Backpressure: o_busy tells the core to stall; no other flow control.
// master = core decode side, slave = mdu_sequencer.
interface mdu_sequencer_if #(
  parameter int WIDTH = mdu_pkg::MDU_WIDTH
) ();
  logic             i_start;
  logic [5:0]       i_func;
  logic [WIDTH-1:0] i_op_a;
  logic [WIDTH-1:0] i_op_b;
  logic             i_cancel;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_rdata;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic             o_unknown_func;

  modport master (
    output i_start, i_func, i_op_a, i_op_b, i_cancel,
    input  o_busy, o_done, o_rdata, o_hi, o_lo, o_unknown_func
  );

  modport slave (
    input  i_start, i_func, i_op_a, i_op_b, i_cancel,
    output o_busy, o_done, o_rdata, o_hi, o_lo, o_unknown_func
  );
endinterface

// File: rtl/mdu_datapath.sv
// MDU datapath: 2*WIDTH accumulator, one shift-add / restoring-subtract step per cycle, sign fix-up.
// Latency: operands captured on load_i; one iteration per step_i; hi_o/lo_o are combinational from state.
// Backpressure: none; fully slaved to the sequencer's load/step strobes.
// Ports: clk_i/rst_ni (sync, active-low); load_i/signed_i/op_a_i/op_b_i capture; step_i/is_div_i iterate;
//        mul_exit_o flags a multiply that can skip its remaining iterations; hi_o/lo_o fixed-up result.
// Macro MDU_EARLY_OUT_EN adds cnt_i and the early-exit barrel shift; otherwise mul_exit_o is tied low.
module mdu_datapath #(
  parameter int WIDTH = mdu_pkg::MDU_WIDTH
`ifdef MDU_EARLY_OUT_EN
  , parameter int CNT_W = mdu_pkg::MDU_CNT_W
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             step_i,
  input  logic             is_div_i,
`ifdef MDU_EARLY_OUT_EN
  input  logic [CNT_W-1:0] cnt_i,
`endif
  output logic             mul_exit_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // Multiply: acc = {partial product, multiplier}; multiplier (op_a) shifts out of the low end.
  // Divide:   acc = {remainder, dividend/quotient}; quotient bits shift in at the low end.
  // Both load the same way, so capture does not need to know the op type.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q;
  logic               neg_q;   // product/quotient negative
  logic               rneg_q;  // remainder negative (follows dividend)

  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_trial;

  always_comb begin
    sa    = signed_i & op_a_i[WIDTH-1];
    sb    = signed_i & op_b_i[WIDTH-1];
    a_mag = sa ? -op_a_i : op_a_i;
    b_mag = sb ? -op_b_i : op_b_i;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // remainder < divisor, so the shifted remainder always fits in WIDTH+1 bits
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    if (is_div_i) begin
      if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

`ifdef MDU_EARLY_OUT_EN
  // After cnt steps the low WIDTH-cnt bits of acc are the unconsumed multiplier bits.
  // Once they are zero the remaining steps are pure right shifts, done here in one go.
  localparam logic [CNT_W:0] WIDTH_C = (CNT_W+1)'(WIDTH);
  logic [WIDTH-1:0] rem_mask;
  logic [CNT_W:0]   shamt;
  assign rem_mask   = {WIDTH{1'b1}} >> cnt_i;
  assign shamt      = WIDTH_C - {1'b0, cnt_i};
  assign mul_exit_o = step_i && !is_div_i && ((acc_q[WIDTH-1:0] & rem_mask) == '0);
`else
  assign mul_exit_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      b_q    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else if (load_i) begin
      acc_q  <= {{WIDTH{1'b0}}, a_mag};
      b_q    <= b_mag;
      neg_q  <= sa ^ sb;
      rneg_q <= sa;
`ifdef MDU_EARLY_OUT_EN
    end else if (mul_exit_o) begin
      acc_q  <= acc_q >> shamt;
`endif
    end else if (step_i) begin
      acc_q  <= acc_d;
    end
  end

  // Two's-complement sign correction applied to the magnitude result
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    prod = neg_q  ? -acc_q : acc_q;
    quot = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    hi_o = is_div_i ? rem  : prod[2*WIDTH-1:WIDTH];
    lo_o = is_div_i ? quot : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MIPS multiply/divide unit: FSM, iteration counter, HI/LO and core handshake.
// Latency: MULT*/DIV* busy 33 cycles after the start edge, HI/LO written on the 33rd, o_done pulses next cycle.
// Backpressure: o_busy stalls the core; i_start while busy is dropped; i_cancel aborts without writing HI/LO.
// Ports: i_clk, i_rst_n (sync, active-low); bus (slave): i_start/i_func/i_op_a/i_op_b/i_cancel in,
//        o_busy/o_done/o_rdata/o_hi/o_lo/o_unknown_func out.
// Macro MDU_EARLY_OUT_EN lets multiplies leave CALC once the remaining multiplier bits are zero.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input logic            i_clk,
  input logic            i_rst_n,
  mdu_sequencer_if.slave bus
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, is_div_q;

  logic             start_ok, dp_load, dp_step, dp_exit;
  logic [WIDTH-1:0] dp_hi, dp_lo;

  // i_cancel in IDLE suppresses a same-cycle start
  assign start_ok = bus.i_start && !bus.i_cancel;
  assign dp_load  = (state_q == ST_IDLE) && start_ok && is_muldiv(bus.i_func);
  assign dp_step  = (state_q == ST_CALC) && !bus.i_cancel;

  mdu_datapath #(
    .WIDTH (WIDTH)
`ifdef MDU_EARLY_OUT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_dp (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (dp_load),
    .signed_i   (!bus.i_func[0]),
    .op_a_i     (bus.i_op_a),
    .op_b_i     (bus.i_op_b),
    .step_i     (dp_step),
    .is_div_i   (is_div_q),
`ifdef MDU_EARLY_OUT_EN
    .cnt_i      (cnt_q),
`endif
    .mul_exit_o (dp_exit),
    .hi_o       (dp_hi),
    .lo_o       (dp_lo)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            if (is_muldiv(bus.i_func)) begin
              state_q  <= ST_CALC;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              is_div_q <= bus.i_func[1];
            end
            if (bus.i_func == FUNC_MTHI) hi_q <= bus.i_op_a;
            if (bus.i_func == FUNC_MTLO) lo_q <= bus.i_op_a;
          end
        end
        ST_CALC: begin
          if (bus.i_cancel) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (dp_exit) begin
            state_q <= ST_FIX;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;  // wraps to 0 on the final iteration
            if (cnt_q == CNT_W'(WIDTH-1)) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!bus.i_cancel) begin
            hi_q   <= dp_hi;
            lo_q   <= dp_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.o_rdata = '0;
    if (bus.i_func == FUNC_MFHI) bus.o_rdata = hi_q;
    if (bus.i_func == FUNC_MFLO) bus.o_rdata = lo_q;
  end

  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_hi           = hi_q;
  assign bus.o_lo           = lo_q;
  assign bus.o_unknown_func = bus.i_start && !is_known(bus.i_func);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer (default build, fixed 33-cycle latency).
module tb_mdu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_sequencer_if #(.WIDTH(32)) bus ();

  mdu_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one MULT*/DIV*, optionally fire a stray start at busy cycle inj_at, check latency and result.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int inj_at);
    int cyc;
    bus.i_start = 1'b1;
    bus.i_func  = f;
    bus.i_op_a  = a;
    bus.i_op_b  = b;
    tick();
    bus.i_start = 1'b0;
    cyc = 0;
    while (bus.o_busy && cyc < 100) begin
      if (cyc == inj_at) begin
        bus.i_start = 1'b1;
        bus.i_func  = mdu_pkg::FUNC_MULT;
        bus.i_op_a  = 32'd7;
        bus.i_op_b  = 32'd9;
      end
      tick();
      bus.i_start = 1'b0;
      bus.i_func  = f;
      cyc++;
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
    check({tag, "_done"}, {63'd0, bus.o_done}, 64'd1);
    check({tag, "_hi"}, {32'd0, bus.o_hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, bus.o_lo}, {32'd0, exp_lo});
    tick();
    check({tag, "_done_pulse"}, {63'd0, bus.o_done}, 64'd0);
  endtask

  initial begin
    bus.i_start  = 1'b0;
    bus.i_func   = 6'd0;
    bus.i_op_a   = '0;
    bus.i_op_b   = '0;
    bus.i_cancel = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy", {63'd0, bus.o_busy}, 64'd0);
    check("rst_done", {63'd0, bus.o_done}, 64'd0);
    check("rst_hi", {32'd0, bus.o_hi}, 64'd0);
    check("rst_lo", {32'd0, bus.o_lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Arithmetic vectors
    run_op("mult_m1x2",   mdu_pkg::FUNC_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    run_op("multu_m1x2",  mdu_pkg::FUNC_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, -1);
    run_op("div_m7d2",    mdu_pkg::FUNC_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op("div_minneg1", mdu_pkg::FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1);
    run_op("divu_7d0",    mdu_pkg::FUNC_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, -1);

    // MTHI then MFHI
    bus.i_start = 1'b1; bus.i_func = mdu_pkg::FUNC_MTHI; bus.i_op_a = 32'h0000_1234;
    tick();
    bus.i_start = 1'b0; bus.i_func = mdu_pkg::FUNC_MFHI;
    #1;
    check("mthi_busy", {63'd0, bus.o_busy}, 64'd0);
    check("mthi_done", {63'd0, bus.o_done}, 64'd0);
    check("mfhi_rdata", {32'd0, bus.o_rdata}, 64'h1234);

    // MTLO then MFLO
    bus.i_start = 1'b1; bus.i_func = mdu_pkg::FUNC_MTLO; bus.i_op_a = 32'h0000_ABCD;
    tick();
    bus.i_start = 1'b0; bus.i_func = mdu_pkg::FUNC_MFLO;
    #1;
    check("mflo_rdata", {32'd0, bus.o_rdata}, 64'hABCD);
    check("mtlo_hi_kept", {32'd0, bus.o_hi}, 64'h1234);

    // Unknown func: flagged combinationally, no state change
    bus.i_start = 1'b1; bus.i_func = 6'b111111; bus.i_op_a = 32'hDEAD_BEEF;
    #1;
    check("unk_flag", {63'd0, bus.o_unknown_func}, 64'd1);
    tick();
    bus.i_start = 1'b0;
    check("unk_busy", {63'd0, bus.o_busy}, 64'd0);
    check("unk_lo_kept", {32'd0, bus.o_lo}, 64'hABCD);
    bus.i_start = 1'b1; bus.i_func = mdu_pkg::FUNC_MFHI;
    #1;
    check("known_flag", {63'd0, bus.o_unknown_func}, 64'd0);
    bus.i_start = 1'b0;
    tick();

    // Start while busy is ignored
    run_op("multu_ign", mdu_pkg::FUNC_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 4);

    // Cancel at CALC cycle 10
    bus.i_start = 1'b1; bus.i_func = mdu_pkg::FUNC_DIVU; bus.i_op_a = 32'd100; bus.i_op_b = 32'd7;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("cancel_pre_busy", {63'd0, bus.o_busy}, 64'd1);
    bus.i_cancel = 1'b1;
    tick();
    bus.i_cancel = 1'b0;
    check("cancel_busy", {63'd0, bus.o_busy}, 64'd0);
    check("cancel_done", {63'd0, bus.o_done}, 64'd0);
    check("cancel_hi", {32'd0, bus.o_hi}, 64'd0);
    check("cancel_lo", {32'd0, bus.o_lo}, 64'd15);
    for (int i = 0; i < 35; i++) begin
      tick();
      check("cancel_no_done", {63'd0, bus.o_done}, 64'd0);
    end

    // Cancel in IDLE blocks a same-cycle start
    bus.i_start = 1'b1; bus.i_cancel = 1'b1; bus.i_func = mdu_pkg::FUNC_MULT;
    tick();
    bus.i_start = 1'b0; bus.i_cancel = 1'b0;
    check("idle_cancel_busy", {63'd0, bus.o_busy}, 64'd0);

    // Recovery after cancel: full latency again
    run_op("multu_6x7", mdu_pkg::FUNC_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, -1);

    // Reset mid-CALC
    bus.i_start = 1'b1; bus.i_func = mdu_pkg::FUNC_MULTU; bus.i_op_a = 32'd9; bus.i_op_b = 32'd9;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", {63'd0, bus.o_busy}, 64'd0);
    check("midrst_hi", {32'd0, bus.o_hi}, 64'd0);
    check("midrst_lo", {32'd0, bus.o_lo}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 35; i++) begin
      tick();
      check("midrst_no_done", {63'd0, bus.o_done}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
